// File: rtl/rom_loader.sv
// Boot-image loader: packs an 8-bit byte stream little-endian into DW-bit words and writes them to memory.
// Latency: wr_en one cycle after the last byte of a word is accepted; done one cycle after the final write.
// Backpressure: in_ready is high only in LOAD until the final word is assembled; the memory never stalls writes.
//
// Ports:
//   clock, reset_n          system clock, asynchronous active-low reset
//   start, length           begin a load of 'length' words (accepted in IDLE/DONE only)
//   in_data/in_valid/in_ready  byte stream handshake
//   wr_en/wr_address/wr_data   one-cycle memory write per packed word
//   busy, done              LOAD in progress / image complete
//   checksum                mod-256 sum of accepted bytes, present only with `CHECKSUM_EN defined
module rom_loader #(
    parameter int DW = 8,
    parameter int AW = 14
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic [AW:0]   length,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_address,
    output logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          done
`ifdef CHECKSUM_EN
    ,
    output logic [7:0]    checksum
`endif
);

    localparam int BPW = DW / 8;
    // Keep the byte index at least one bit wide so DW=8 still elaborates.
    localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IW-1:0]  byte_idx;
    logic [AW:0]    word_cnt;   // words fully assembled so far
    logic [AW:0]    len_q;
    logic [DW-1:0]  pack;
    logic [DW-1:0]  word_nxt;
    logic           start_acc;
    logic           take;
    logic           word_end;
    logic           final_wr;

    assign busy     = (state == S_LOAD);
    assign done     = (state == S_DONE);
    // Once the final word is assembled (word_cnt == len_q) no further bytes are taken,
    // which covers the final wr_en cycle and everything after it.
    assign in_ready = (state == S_LOAD) && (word_cnt != len_q);

    always_comb begin
        start_acc = start && (state != S_LOAD);
        take      = in_valid && in_ready;
        word_end  = take && (byte_idx == IW'(BPW - 1));
        final_wr  = wr_en && (word_cnt == len_q);
        word_nxt  = pack;
        word_nxt[8*byte_idx +: 8] = in_data;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = (length == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (final_wr) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            byte_idx   <= '0;
            word_cnt   <= '0;
            len_q      <= '0;
            pack       <= '0;
            wr_en      <= 1'b0;
            wr_address <= '0;
            wr_data    <= '0;
        end else begin
            wr_en <= word_end;
            if (start_acc) begin
                byte_idx   <= '0;
                word_cnt   <= '0;
                len_q      <= length;
                pack       <= '0;
                wr_address <= '0;
            end else begin
                // Address advances after each write; a full-capacity load wraps it to 0
                // after the last write without producing another write.
                if (wr_en) begin
                    wr_address <= wr_address + 1'b1;
                end
                if (take) begin
                    pack <= word_nxt;
                    if (word_end) begin
                        byte_idx <= '0;
                        word_cnt <= word_cnt + 1'b1;
                        wr_data  <= word_nxt;
                    end else begin
                        byte_idx <= byte_idx + 1'b1;
                    end
                end
            end
        end
    end

`ifdef CHECKSUM_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            checksum <= 8'h00;
        end else if (start_acc) begin
            checksum <= 8'h00;
        end else if (take) begin
            checksum <= checksum + in_data;
        end
    end
`endif

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: three instances (DW=8/16/32, AW=4) exercised one at a time.
// Expected writes are queued by the stimulus and popped by an independent write monitor.
// Status outputs (ready/busy/done/reset values) are compared directly by the stimulus.
module tb_rom_loader;

    logic       clock;
    logic       reset_n;
    logic       start_v [3];
    logic [4:0] len_v   [3];
    logic [7:0] din     [3];
    logic       vld     [3];
    logic       rdy     [3];
    logic       wen     [3];
    logic [3:0] waddr   [3];
    logic [31:0] wdat   [3];
    logic       busy_w  [3];
    logic       done_w  [3];
    logic [7:0] cs      [3];
    logic [7:0]  wd8;
    logic [15:0] wd16;
    logic [31:0] wd32;
    logic        acc_d  [3];

    int checks = 0;
    int errors = 0;

    // Scoreboard entry: {unit[1:0], address[3:0], data[31:0]}
    logic [37:0] exp_q [$];

    assign wdat[0] = {24'h0, wd8};
    assign wdat[1] = {16'h0, wd16};
    assign wdat[2] = wd32;

    rom_loader #(.DW(8), .AW(4)) u8 (
        .clock(clock), .reset_n(reset_n), .start(start_v[0]), .length(len_v[0]),
        .in_data(din[0]), .in_valid(vld[0]), .in_ready(rdy[0]), .wr_en(wen[0]),
        .wr_address(waddr[0]), .wr_data(wd8), .busy(busy_w[0]), .done(done_w[0])
`ifdef CHECKSUM_EN
        , .checksum(cs[0])
`endif
    );

    rom_loader #(.DW(16), .AW(4)) u16 (
        .clock(clock), .reset_n(reset_n), .start(start_v[1]), .length(len_v[1]),
        .in_data(din[1]), .in_valid(vld[1]), .in_ready(rdy[1]), .wr_en(wen[1]),
        .wr_address(waddr[1]), .wr_data(wd16), .busy(busy_w[1]), .done(done_w[1])
`ifdef CHECKSUM_EN
        , .checksum(cs[1])
`endif
    );

    rom_loader #(.DW(32), .AW(4)) u32 (
        .clock(clock), .reset_n(reset_n), .start(start_v[2]), .length(len_v[2]),
        .in_data(din[2]), .in_valid(vld[2]), .in_ready(rdy[2]), .wr_en(wen[2]),
        .wr_address(waddr[2]), .wr_data(wd32), .busy(busy_w[2]), .done(done_w[2])
`ifdef CHECKSUM_EN
        , .checksum(cs[2])
`endif
    );

`ifndef CHECKSUM_EN
    initial begin
        for (int i = 0; i < 3; i++) cs[i] = 8'h00;
    end
`endif

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Write monitor: every wr_en must match the head of the queue and follow an accepted byte.
    always @(negedge clock) begin
        logic [37:0] e;
        logic [37:0] got;
        for (int u = 0; u < 3; u++) begin
            if (wen[u]) begin
                got = {u[1:0], waddr[u], wdat[u]};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected: got %h expected no write at %0t", got, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL wr_word: got %h expected %h at %0t", got, e, $time);
                    end
                end
                checks++;
                if (acc_d[u] !== 1'b1) begin
                    errors++;
                    $display("FAIL wr_latency: unit %0d write without byte accepted previous cycle at %0t", u, $time);
                end
            end
        end
        for (int u = 0; u < 3; u++) acc_d[u] = vld[u] & rdy[u];
    end

    task automatic push(input int u, input int a, input logic [31:0] d);
        logic [1:0] uu;
        logic [3:0] aa;
        uu = u[1:0];
        aa = a[3:0];
        exp_q.push_back({uu, aa, d});
    endtask

    task automatic do_start(input int u, input int len);
        start_v[u] = 1'b1;
        len_v[u]   = len[4:0];
        @(posedge clock); #1;
        start_v[u] = 1'b0;
    endtask

    task automatic send(input int u, input logic [7:0] b);
        int n;
        n = 0;
        din[u] = b;
        vld[u] = 1'b1;
        @(negedge clock);
        while (!rdy[u] && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("send_accept", {63'h0, rdy[u]}, 64'h1);
        @(posedge clock); #1;
        vld[u] = 1'b0;
    endtask

    task automatic wait_done(input int u);
        int n;
        n = 0;
        @(negedge clock);
        while (!done_w[u] && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("done_reached", {63'h0, done_w[u]}, 64'h1);
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0; len_v[i] = '0; din[i] = '0; vld[i] = 1'b0; acc_d[i] = 1'b0;
        end
        #22;
        for (int u = 0; u < 3; u++) begin
            chk("rst_outputs", {busy_w[u], done_w[u], rdy[u], wen[u], waddr[u], wdat[u]}, 64'h0);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        chk("idle_ready", {61'h0, rdy[1], busy_w[1], done_w[1]}, 64'h0);

        // 1: DW=16, three words back-to-back
        do_start(1, 3);
        push(1, 0, 32'h2211); push(1, 1, 32'h4433); push(1, 2, 32'h6655);
        send(1, 8'h11); send(1, 8'h22); send(1, 8'h33);
        send(1, 8'h44); send(1, 8'h55); send(1, 8'h66);
        @(negedge clock);
        chk("t1_final_wr_cycle", {61'h0, wen[1], busy_w[1], rdy[1]}, 64'h6);
        @(posedge clock); #1;
        vld[1] = 1'b1; din[1] = 8'h77;
        @(negedge clock);
        chk("t1_done_state", {61'h0, done_w[1], busy_w[1], rdy[1]}, 64'h4);
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("t1_no_extra_accept", {63'h0, rdy[1]}, 64'h0);
        @(posedge clock); #1;
        vld[1] = 1'b0;

        // 2: DW=8, gapped stream
        do_start(0, 4);
        for (int i = 0; i < 4; i++) push(0, i, 32'hA0 + i);
        for (int i = 0; i < 4; i++) begin
            send(0, 8'hA0 + i[7:0]);
            @(posedge clock); #1;
        end
        wait_done(0);

        // Full capacity: 16 words with AW=4, address wraps to 0 afterwards
        do_start(0, 16);
        for (int i = 0; i < 16; i++) push(0, i, 32'h30 + i);
        for (int i = 0; i < 16; i++) send(0, 8'h30 + i[7:0]);
        wait_done(0);
        chk("full_addr_wrap", {60'h0, waddr[0]}, 64'h0);
        chk("full_ready_low", {63'h0, rdy[0]}, 64'h0);

        // 3: zero-length load
        do_start(1, 0);
        @(negedge clock);
        chk("t3_zero_len", {61'h0, done_w[1], busy_w[1], rdy[1]}, 64'h4);
        repeat (3) @(posedge clock); #1;
        chk("t3_zero_len_hold", {62'h0, done_w[1], rdy[1]}, 64'h2);

        // 4: DW=32, reset after five bytes
        do_start(2, 2);
        push(2, 0, 32'h04030201);
        for (int i = 1; i <= 5; i++) send(2, i[7:0]);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t4_async_reset", {busy_w[2], done_w[2], rdy[2], wen[2], waddr[2], wdat[2]}, 64'h0);
        chk("t4_reset_other", {62'h0, done_w[0], done_w[1]}, 64'h0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        do_start(2, 1);
        push(2, 0, 32'h04030201);
        for (int i = 1; i <= 4; i++) send(2, i[7:0]);
        wait_done(2);

        // 5: start during LOAD ignored, start in DONE restarts at address 0
        do_start(1, 2);
        push(1, 0, 32'hBBAA); push(1, 1, 32'hDDCC);
        send(1, 8'hAA); send(1, 8'hBB);
        start_v[1] = 1'b1; len_v[1] = 5'd5;
        send(1, 8'hCC);
        start_v[1] = 1'b0;
        send(1, 8'hDD);
        wait_done(1);
        chk("t5_addr_after", {60'h0, waddr[1]}, 64'h2);
        do_start(1, 1);
        @(negedge clock);
        chk("t5_restart", {62'h0, done_w[1], busy_w[1]}, 64'h1);
        push(1, 0, 32'hF00D);
        @(posedge clock); #1;
        send(1, 8'h0D); send(1, 8'hF0);
        wait_done(1);

`ifdef CHECKSUM_EN
        // 6: checksum accumulate and clear
        do_start(0, 3);
        push(0, 0, 32'hFF); push(0, 1, 32'h02); push(0, 2, 32'h10);
        send(0, 8'hFF); send(0, 8'h02); send(0, 8'h10);
        wait_done(0);
        chk("t6_checksum", {56'h0, cs[0]}, 64'h11);
        do_start(0, 0);
        chk("t6_checksum_clear", {56'h0, cs[0]}, 64'h0);
`endif

        repeat (4) @(posedge clock);
        #1;
        chk("sb_drained", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
